// File: rtl/wam_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// wam_display_ctrl_if
// Bundles the game-event inputs and the display/status outputs of the
// whack-a-mole round controller.
//   start        : single-cycle pulse, begins a round
//   hit          : single-cycle pulse, one successful whack
//   show_high    : level, selects high score while idle
//   bin_out      : 6-bit value for the decoder's b input
//   dec_enable   : decoder enable
//   game_active  : round in progress
//   game_over    : round finished, waiting for restart
//   new_high     : one-cycle pulse on a new high score
//   showing_time : bin_out currently carries time remaining
// master = game/hit logic side, slave = controller side.
// ---------------------------------------------------------------------------
interface wam_display_ctrl_if;
   logic       start;
   logic       hit;
   logic       show_high;
   logic [5:0] bin_out;
   logic       dec_enable;
   logic       game_active;
   logic       game_over;
   logic       new_high;
   logic       showing_time;

   modport master (
      output start, hit, show_high,
      input  bin_out, dec_enable, game_active, game_over, new_high, showing_time
   );

   modport slave (
      input  start, hit, show_high,
      output bin_out, dec_enable, game_active, game_over, new_high, showing_time
   );
endinterface

// File: rtl/wam_display_ctrl.sv
// ---------------------------------------------------------------------------
// wam_display_ctrl
// Round controller for the whack-a-mole score display. Owns the round
// countdown, the hit score and the high score, and time-shares one
// two-digit binary-to-decimal decoder between them.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears all state including high score
//   bus   : wam_display_ctrl_if.slave (game events in, decoder drive out)
// Outputs are decoded from registered state only, except that show_high
// steers bin_out directly while idle.
// ---------------------------------------------------------------------------
module wam_display_ctrl #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int GAME_SECONDS  = 60
) (
   input logic               clk,
   input logic               reset,
   wam_display_ctrl_if.slave bus
);

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_SEC / 2);
   localparam logic [5:0]    ROUND_SEC = 6'(GAME_SECONDS);

   typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

   state_t        state;
   logic [5:0]    score;
   logic [5:0]    high;
   logic [5:0]    time_left;
   logic [TW-1:0] tick;
   logic          new_high_r;

   logic [5:0]    score_hit;
   logic          tick_wrap;
   logic          first_half;

   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == 6'd63) ? v : v + 6'd1;
   endfunction

   // A hit on the final-wrap cycle must feed the high-score compare.
   assign score_hit  = bus.hit ? sat_inc(score) : score;
   assign tick_wrap  = (tick == TICK_LAST);
   assign first_half = (tick < TICK_HALF);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         score      <= 6'd0;
         high       <= 6'd0;
         time_left  <= 6'd0;
         tick       <= '0;
         new_high_r <= 1'b0;
      end else begin
         new_high_r <= 1'b0;
         case (state)
            IDLE: begin
               tick <= '0;
               if (bus.start) begin
                  score     <= 6'd0;
                  time_left <= ROUND_SEC;
                  state     <= PLAYING;
               end
            end
            PLAYING: begin
               score <= score_hit;
               if (tick_wrap) begin
                  tick      <= '0;
                  time_left <= time_left - 6'd1;
                  if (time_left == 6'd1) begin
                     state <= OVER;
                     if (score_hit > high) begin
                        high       <= score_hit;
                        new_high_r <= 1'b1;
                     end
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            OVER: begin
               if (bus.start) begin
                  score     <= 6'd0;
                  time_left <= ROUND_SEC;
                  tick      <= '0;
                  state     <= PLAYING;
               end else begin
                  tick <= tick_wrap ? '0 : tick + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.bin_out      = score;
      bus.dec_enable   = 1'b1;
      bus.game_active  = 1'b0;
      bus.game_over    = 1'b0;
      bus.showing_time = 1'b0;
      case (state)
         IDLE: begin
            bus.bin_out = bus.show_high ? high : score;
         end
         PLAYING: begin
            bus.game_active = 1'b1;
            // First half of each second shows the countdown, second half the score.
            if (first_half) begin
               bus.bin_out      = time_left;
               bus.showing_time = 1'b1;
            end
         end
         OVER: begin
            bus.game_over  = 1'b1;
            bus.dec_enable = first_half;
         end
         default: ;
      endcase
   end

   assign bus.new_high = new_high_r;

endmodule
